// File: rtl/pipe_ctl_stages_pkg.sv
// Shared types for the D->E->M->W control pipeline.
// Optional statistics counters elsewhere are enabled by defining PIPE_STATS_EN.
package pipe_ctl_pkg;

  // ALU control width carried inside the control bundle
  localparam int CTL_ALUC_W = 4;

  // jal writes its return address here
  localparam logic [4:0] RA_REG = 5'd31;

  // Decoded control bundle that travels down the pipe
  typedef struct packed {
    logic                  wreg;
    logic                  m2reg;
    logic                  wmem;
    logic                  jal;
    logic                  aluimm;
    logic                  shift;
    logic [CTL_ALUC_W-1:0] aluc;
  } ctl_t;

  // Bubble / squashed slot: no side effects anywhere downstream
  localparam ctl_t CTL_NOP = '0;

endpackage

// File: rtl/pipe_ctl_stages_if.sv
// Decode-side and datapath-side control signals of the pipeline control stages.
// The counter signals exist only when PIPE_STATS_EN is defined.
interface pipe_ctl_stages_if #(
  parameter int RN_W   = 5,
  parameter int ALUC_W = 4
`ifdef PIPE_STATS_EN
  , parameter int CNT_W = 32
`endif
);

  // D-stage controls from the decode control unit
  logic              dwreg;
  logic              dm2reg;
  logic              dwmem;
  logic              djal;
  logic              dregrt;
  logic [ALUC_W-1:0] daluc;
  logic              daluimm;
  logic              dshift;
  logic [RN_W-1:0]   drt;
  logic [RN_W-1:0]   drd;
  logic [1:0]        dpcsource;
  logic              wpcir;

  // E/M/W stage controls and hazard feedback
  logic              ewreg;
  logic              em2reg;
  logic              ewmem;
  logic              ejal;
  logic              ealuimm;
  logic              eshift;
  logic [ALUC_W-1:0] ealuc;
  logic [RN_W-1:0]   ern;
  logic              ebubble;
  logic              mwreg;
  logic              mm2reg;
  logic              mwmem;
  logic [RN_W-1:0]   mrn;
  logic              wwreg;
  logic              wm2reg;
  logic [RN_W-1:0]   wrn;
`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  squash_cnt;
`endif

  // Decode side: drives D controls, consumes stage state
  modport master (
    output dwreg, dm2reg, dwmem, djal, dregrt, daluc, daluimm, dshift,
           drt, drd, dpcsource, wpcir,
    input  ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ealuc, ern, ebubble,
           mwreg, mm2reg, mwmem, mrn, wwreg, wm2reg, wrn
`ifdef PIPE_STATS_EN
    , input stall_cnt, squash_cnt
`endif
  );

  // Pipeline control block side
  modport slave (
    input  dwreg, dm2reg, dwmem, djal, dregrt, daluc, daluimm, dshift,
           drt, drd, dpcsource, wpcir,
    output ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ealuc, ern, ebubble,
           mwreg, mm2reg, mwmem, mrn, wwreg, wm2reg, wrn
`ifdef PIPE_STATS_EN
    , output stall_cnt, squash_cnt
`endif
  );

endinterface

// File: rtl/pipe_ctl_stages_stage.sv
// One pipeline register holding a control bundle and its destination register.
// A synchronous bubble loads the NOP bundle instead of the incoming one.
module pipe_ctl_stage
  import pipe_ctl_pkg::*;
#(
  parameter int RN_W = 5
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            bubble,
  input  ctl_t            d_ctl,
  input  logic [RN_W-1:0] d_rn,
  output ctl_t            q_ctl,
  output logic [RN_W-1:0] q_rn
);

  // Stage register: clear on reset, zero on bubble, otherwise advance
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q_ctl <= CTL_NOP;
      q_rn  <= '0;
    end else if (bubble) begin
      q_ctl <= CTL_NOP;
      q_rn  <= '0;
    end else begin
      q_ctl <= d_ctl;
      q_rn  <= d_rn;
    end
  end

endmodule

// File: rtl/pipe_ctl_stages.sv
// Carries decoded controls from D through E, M and W and returns the hazard
// feedback used by decode. Define PIPE_STATS_EN to add stall/squash counters.
module pipe_ctl_stages
  import pipe_ctl_pkg::*;
#(
  parameter int RN_W = 5
`ifdef PIPE_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clock,
  input  logic              resetn,
  pipe_ctl_stages_if.slave  bus
);

  ctl_t            d_ctl, e_ctl, m_ctl, w_ctl;
  logic [RN_W-1:0] drn, ern, mrn, wrn;
  logic            ebubble_reg;

  // Bundle the D controls and pick the destination register
  always_comb begin
    d_ctl        = CTL_NOP;
    d_ctl.wreg   = bus.dwreg;
    d_ctl.m2reg  = bus.dm2reg;
    d_ctl.wmem   = bus.dwmem;
    d_ctl.jal    = bus.djal;
    d_ctl.aluimm = bus.daluimm;
    d_ctl.shift  = bus.dshift;
    d_ctl.aluc   = bus.daluc;
    drn          = bus.djal ? RN_W'(RA_REG) : (bus.dregrt ? bus.drt : bus.drd);
  end

  // E takes a bubble whenever decode is stalled on a load-use hazard
  pipe_ctl_stage #(.RN_W(RN_W)) u_e_stage (
    .clock(clock), .resetn(resetn), .bubble(~bus.wpcir),
    .d_ctl(d_ctl), .d_rn(drn), .q_ctl(e_ctl), .q_rn(ern)
  );

  pipe_ctl_stage #(.RN_W(RN_W)) u_m_stage (
    .clock(clock), .resetn(resetn), .bubble(1'b0),
    .d_ctl(e_ctl), .d_rn(ern), .q_ctl(m_ctl), .q_rn(mrn)
  );

  pipe_ctl_stage #(.RN_W(RN_W)) u_w_stage (
    .clock(clock), .resetn(resetn), .bubble(1'b0),
    .d_ctl(m_ctl), .d_rn(mrn), .q_ctl(w_ctl), .q_rn(wrn)
  );

  // Flag the slot after a taken transfer; a stall cycle never sets it
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) ebubble_reg <= 1'b0;
    else         ebubble_reg <= bus.wpcir & (bus.dpcsource != 2'b00);
  end

  // Fields that only matter in E are dropped by synthesis past that stage
  logic unused_ctl;
  assign unused_ctl = ^{m_ctl.jal, m_ctl.aluimm, m_ctl.shift, m_ctl.aluc,
                        w_ctl.wmem, w_ctl.jal, w_ctl.aluimm, w_ctl.shift, w_ctl.aluc};

  assign bus.ewreg   = e_ctl.wreg;
  assign bus.em2reg  = e_ctl.m2reg;
  assign bus.ewmem   = e_ctl.wmem;
  assign bus.ejal    = e_ctl.jal;
  assign bus.ealuimm = e_ctl.aluimm;
  assign bus.eshift  = e_ctl.shift;
  assign bus.ealuc   = e_ctl.aluc;
  assign bus.ern     = ern;
  assign bus.ebubble = ebubble_reg;
  assign bus.mwreg   = m_ctl.wreg;
  assign bus.mm2reg  = m_ctl.m2reg;
  assign bus.mwmem   = m_ctl.wmem;
  assign bus.mrn     = mrn;
  assign bus.wwreg   = w_ctl.wreg;
  assign bus.wm2reg  = w_ctl.m2reg;
  assign bus.wrn     = wrn;

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_reg, squash_cnt_reg;

  // Count stalled cycles and squashed slots; both wrap naturally
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_reg  <= '0;
      squash_cnt_reg <= '0;
    end else begin
      if (!bus.wpcir)  stall_cnt_reg  <= stall_cnt_reg + 1'b1;
      if (ebubble_reg) squash_cnt_reg <= squash_cnt_reg + 1'b1;
    end
  end

  assign bus.stall_cnt  = stall_cnt_reg;
  assign bus.squash_cnt = squash_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_ctl_stages.sv
// Directed bench for pipe_ctl_stages; covers counters when PIPE_STATS_EN is defined.
module tb_pipe_ctl_stages;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  pipe_ctl_stages_if bus ();

  pipe_ctl_stages dut (
    .clock(clock),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // Every stage output packed together for all-zero checks
  function automatic logic [30:0] all_outs();
    return {bus.ewreg, bus.em2reg, bus.ewmem, bus.ejal, bus.ealuimm, bus.eshift,
            bus.ealuc, bus.ern, bus.ebubble, bus.mwreg, bus.mm2reg, bus.mwmem,
            bus.mrn, bus.wwreg, bus.wm2reg, bus.wrn};
  endfunction

  task automatic set_d(input logic wreg, input logic m2reg, input logic wmem,
                       input logic jal, input logic regrt, input logic [3:0] aluc,
                       input logic aluimm, input logic shift, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [1:0] pcs, input logic wpcir);
    bus.dwreg = wreg;   bus.dm2reg = m2reg;   bus.dwmem = wmem;   bus.djal = jal;
    bus.dregrt = regrt; bus.daluc = aluc;     bus.daluimm = aluimm;
    bus.dshift = shift; bus.drt = rt;         bus.drd = rd;
    bus.dpcsource = pcs; bus.wpcir = wpcir;
  endtask

  task automatic set_nop();
    set_d(0, 0, 0, 0, 0, 4'h0, 0, 0, 5'd0, 5'd0, 2'b00, 1);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    set_d(1, 1, 1, 1, 0, 4'hF, 1, 1, 5'd9, 5'd9, 2'b11, 1);
    tick();
    tick();
    total++;
    if (all_outs() !== 31'd0) begin
      bad++; $display("FAIL reset_outs: got %h want 0", all_outs());
    end
    total++;
    if (bus.ern !== 5'd0) begin bad++; $display("FAIL reset_ern: got %0d want 0", bus.ern); end
    @(negedge clock);
    set_nop();
    resetn = 1'b1;
    tick();
    $display("reset: outs=%h", all_outs());
  endtask

  task automatic test_load();
    set_d(1, 1, 0, 0, 1, 4'h0, 1, 0, 5'd2, 5'd7, 2'b00, 1);  // lw r2
    tick();
    total++;
    if ({bus.ern, bus.em2reg, bus.ewreg, bus.ealuimm} !== {5'd2, 1'b1, 1'b1, 1'b1}) begin
      bad++; $display("FAIL load_e: ern=%0d m2reg=%b wreg=%b aluimm=%b want 2 1 1 1",
                      bus.ern, bus.em2reg, bus.ewreg, bus.ealuimm);
    end
    set_nop();
    tick();
    total++;
    if ({bus.mrn, bus.mm2reg, bus.mwreg, bus.ern} !== {5'd2, 1'b1, 1'b1, 5'd0}) begin
      bad++; $display("FAIL load_m: mrn=%0d mm2reg=%b mwreg=%b ern=%0d want 2 1 1 0",
                      bus.mrn, bus.mm2reg, bus.mwreg, bus.ern);
    end
    tick();
    total++;
    if ({bus.wrn, bus.wm2reg, bus.wwreg, bus.mwreg} !== {5'd2, 1'b1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL load_w: wrn=%0d wm2reg=%b wwreg=%b mwreg=%b want 2 1 1 0",
                      bus.wrn, bus.wm2reg, bus.wwreg, bus.mwreg);
    end
    $display("load: ern/mrn/wrn path done wrn=%0d", bus.wrn);
  endtask

  task automatic test_stall();
    set_d(0, 0, 1, 0, 1, 4'h0, 1, 0, 5'd6, 5'd0, 2'b00, 1);  // sw
    tick();
    set_d(1, 0, 0, 0, 0, 4'h2, 0, 0, 5'd9, 5'd3, 2'b00, 0);  // add r3, stalled
    tick();
    total++;
    if ({bus.ewreg, bus.ewmem, bus.ern, bus.ealuc} !== {1'b0, 1'b0, 5'd0, 4'h0}) begin
      bad++; $display("FAIL stall_bubble: wreg=%b wmem=%b ern=%0d aluc=%h want 0 0 0 0",
                      bus.ewreg, bus.ewmem, bus.ern, bus.ealuc);
    end
    total++;
    if (bus.mwmem !== 1'b1) begin bad++; $display("FAIL stall_drain: mwmem=%b want 1", bus.mwmem); end
    bus.wpcir = 1'b1;
    tick();
    total++;
    if ({bus.ern, bus.ewreg, bus.ealuc, bus.mwmem} !== {5'd3, 1'b1, 4'h2, 1'b0}) begin
      bad++; $display("FAIL stall_release: ern=%0d wreg=%b aluc=%h mwmem=%b want 3 1 2 0",
                      bus.ern, bus.ewreg, bus.ealuc, bus.mwmem);
    end
    $display("stall: add r3 entered E after one bubble");
  endtask

  task automatic test_back_to_back();
    bus.wpcir = 1'b0;
    tick();
    total++;
    if ({bus.ewreg, bus.mwreg, bus.mrn} !== {1'b0, 1'b1, 5'd3}) begin
      bad++; $display("FAIL b2b_stall1: ewreg=%b mwreg=%b mrn=%0d want 0 1 3",
                      bus.ewreg, bus.mwreg, bus.mrn);
    end
    tick();
    total++;
    if ({bus.ewreg, bus.mwreg, bus.wwreg, bus.wrn} !== {1'b0, 1'b0, 1'b1, 5'd3}) begin
      bad++; $display("FAIL b2b_stall2: ewreg=%b mwreg=%b wwreg=%b wrn=%0d want 0 0 1 3",
                      bus.ewreg, bus.mwreg, bus.wwreg, bus.wrn);
    end
    set_nop();
    tick();
    $display("back_to_back: two bubbles inserted, M/W drained");
  endtask

  task automatic test_jal();
    set_d(1, 0, 0, 1, 0, 4'h0, 0, 0, 5'd0, 5'd5, 2'b11, 1);
    tick();
    total++;
    if ({bus.ern, bus.ewreg, bus.ejal, bus.ebubble} !== {5'd31, 1'b1, 1'b1, 1'b1}) begin
      bad++; $display("FAIL jal_e: ern=%0d wreg=%b jal=%b ebubble=%b want 31 1 1 1",
                      bus.ern, bus.ewreg, bus.ejal, bus.ebubble);
    end
    set_nop();
    tick();
    total++;
    if ({bus.ebubble, bus.ejal} !== 2'b00) begin
      bad++; $display("FAIL jal_after: ebubble=%b ejal=%b want 0 0", bus.ebubble, bus.ejal);
    end
    $display("jal: ern=31 with one-cycle ebubble");
  endtask

  task automatic test_stall_branch();
    set_d(1, 0, 0, 1, 0, 4'h0, 0, 0, 5'd0, 5'd0, 2'b10, 1);
    tick();
    set_d(1, 0, 0, 0, 0, 4'h1, 0, 0, 5'd0, 5'd4, 2'b01, 0);
    tick();
    total++;
    if ({bus.ebubble, bus.ewreg, bus.ern} !== {1'b0, 1'b0, 5'd0}) begin
      bad++; $display("FAIL stall_branch: ebubble=%b ewreg=%b ern=%0d want 0 0 0",
                      bus.ebubble, bus.ewreg, bus.ern);
    end
    bus.wpcir = 1'b1;
    tick();
    total++;
    if ({bus.ebubble, bus.ern} !== {1'b1, 5'd4}) begin
      bad++; $display("FAIL branch_release: ebubble=%b ern=%0d want 1 4", bus.ebubble, bus.ern);
    end
    set_nop();
    tick();
    $display("stall_branch: stall dominated, branch taken afterwards");
  endtask

  task automatic test_r0();
    set_d(1, 0, 0, 0, 0, 4'h3, 1, 1, 5'd0, 5'd0, 2'b00, 1);
    tick();
    total++;
    if ({bus.ewreg, bus.ern, bus.ealuimm, bus.eshift, bus.ealuc} !== {1'b1, 5'd0, 1'b1, 1'b1, 4'h3}) begin
      bad++; $display("FAIL r0_e: wreg=%b ern=%0d aluimm=%b shift=%b aluc=%h want 1 0 1 1 3",
                      bus.ewreg, bus.ern, bus.ealuimm, bus.eshift, bus.ealuc);
    end
    set_nop();
    tick();
    total++;
    if ({bus.mwreg, bus.mrn} !== {1'b1, 5'd0}) begin
      bad++; $display("FAIL r0_m: mwreg=%b mrn=%0d want 1 0", bus.mwreg, bus.mrn);
    end
    tick();
    $display("r0: write to r0 carried through");
  endtask

  task automatic test_async_reset();
    set_d(1, 1, 0, 0, 1, 4'h0, 1, 0, 5'd2, 5'd0, 2'b00, 1);
    tick();
    set_d(1, 0, 0, 0, 0, 4'h2, 0, 0, 5'd0, 5'd3, 2'b01, 1);
    tick();
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if (all_outs() !== 31'd0) begin
      bad++; $display("FAIL async_reset: got %h want 0", all_outs());
    end
    @(negedge clock);
    set_nop();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({bus.ewreg, bus.mwreg, bus.wwreg} !== 3'b000) begin
        bad++; $display("FAIL post_reset%0d: e/m/w wreg=%b%b%b want 000",
                        i, bus.ewreg, bus.mwreg, bus.wwreg);
      end
    end
    $display("async_reset: in-flight controls discarded");
  endtask

`ifdef PIPE_STATS_EN
  task automatic test_stats();
    @(negedge clock);
    resetn = 1'b0;
    #1;
    total++;
    if ({bus.stall_cnt, bus.squash_cnt} !== '0) begin
      bad++; $display("FAIL stats_reset: stall=%0d squash=%0d want 0 0", bus.stall_cnt, bus.squash_cnt);
    end
    @(negedge clock);
    resetn = 1'b1;
    set_nop();
    bus.wpcir = 1'b0;
    tick(); tick(); tick();
    set_d(0, 0, 0, 0, 0, 4'h0, 0, 0, 5'd0, 5'd0, 2'b01, 1);
    tick();
    set_nop();
    tick();
    set_d(0, 0, 0, 0, 0, 4'h0, 0, 0, 5'd0, 5'd0, 2'b10, 1);
    tick();
    set_nop();
    tick();
    tick();
    total++;
    if (bus.stall_cnt !== 32'd3) begin
      bad++; $display("FAIL stall_cnt: got %0d want 3", bus.stall_cnt);
    end
    total++;
    if (bus.squash_cnt !== 32'd2) begin
      bad++; $display("FAIL squash_cnt: got %0d want 2", bus.squash_cnt);
    end
    $display("stats: stall_cnt=%0d squash_cnt=%0d", bus.stall_cnt, bus.squash_cnt);
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_back_to_back();
    test_jal();
    test_stall_branch();
    test_r0();
    test_async_reset();
`ifdef PIPE_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
